// File: rtl/adder_arbiter.sv
// Round-robin arbiter and sequencer for the shared tri-state adder.
// Two clients each hand over an operand pair and receive the WIDTH+1 bit sum.
module adder_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,

    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,

    output logic [WIDTH:0]   rsp_s,

    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_en,
    input  logic [WIDTH:0]   add_s,

    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e           state_q;
    logic             last_q;
    logic             owner_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH:0]   res_q;
    logic             add_en_q;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;
    logic             busy_q;

    logic             grant0;
    logic             grant1;
    logic             owner_ready;

    // last_q names the most recent winner; the other client wins a tie.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StIdle) begin
            grant0 = req0_valid & (~req1_valid | last_q);
            grant1 = req1_valid & (~req0_valid | ~last_q);
        end
    end

    assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            res_q        <= '0;
            add_en_q     <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant0 || grant1) begin
                        op_a_q   <= grant1 ? req1_a : req0_a;
                        op_b_q   <= grant1 ? req1_b : req0_b;
                        owner_q  <= grant1;
                        add_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= StExec;
                    end
                end
                StExec: begin
                    // The bus is only trusted while we are the one enabling it.
                    res_q        <= add_s;
                    add_en_q     <= 1'b0;
                    rsp0_valid_q <= ~owner_q;
                    rsp1_valid_q <= owner_q;
                    state_q      <= StResp;
                end
                StResp: begin
                    if (owner_ready) begin
                        last_q       <= owner_q;
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    add_en_q     <= 1'b0;
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_s      = res_q;
    assign add_a      = op_a_q;
    assign add_b      = op_b_q;
    assign add_en     = add_en_q;
    assign busy       = busy_q;

    a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp0_valid && rsp1_valid));
    a_req_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !(req0_ready && req1_ready));
    a_en_busy: assert property (@(posedge clk) disable iff (!rst_n)
        add_en |-> busy);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural tri-state adder and a result scoreboard.
module tb_adder_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0_valid = 1'b0;
    logic       req1_valid = 1'b0;
    logic       rsp0_ready = 1'b0;
    logic       rsp1_ready = 1'b0;
    logic [7:0] req0_a = '0;
    logic [7:0] req0_b = '0;
    logic [7:0] req1_a = '0;
    logic [7:0] req1_b = '0;
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic       add_en, busy;
    logic [8:0] rsp_s;
    logic [7:0] add_a, add_b;
    logic [8:0] add_s;
    logic [8:0] junk = 9'h1AA;

    int checks = 0;
    int failures = 0;

    // Reference model of the arbiter protocol.
    int         m_st = 0;
    logic       m_last = 1'b1;
    logic       m_own = 1'b0;
    logic [7:0] m_a = '0;
    logic [7:0] m_b = '0;
    logic [8:0] sb[$];
    int         grants[$];

    always #5 clk = ~clk;

    // Garbage on the bus whenever the adder is not enabled.
    assign add_s = add_en ? ({1'b0, add_a} + {1'b0, add_b}) : junk;

    adder_arbiter #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_s      (rsp_s),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_en     (add_en),
        .add_s      (add_s),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st   = 0;
        m_last = 1'b1;
        m_own  = 1'b0;
        m_a    = '0;
        m_b    = '0;
        sb.delete();
    endtask

    // Called shortly after a rising edge with inputs already set; checks the cycle and
    // advances the model and the clock by one cycle.
    task automatic observe();
        logic       eg0, eg1;
        logic       take;
        logic [8:0] s;
        #1;
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (m_st == 0) begin
            eg0 = req0_valid & (~req1_valid | m_last);
            eg1 = req1_valid & (~req0_valid | ~m_last);
        end
        check("req0_ready", req0_ready, eg0);
        check("req1_ready", req1_ready, eg1);
        check("add_en", add_en, m_st == 1);
        check("busy", busy, m_st != 0);
        check("rsp0_valid", rsp0_valid, (m_st == 2) && !m_own);
        check("rsp1_valid", rsp1_valid, (m_st == 2) && m_own);
        check("add_a", add_a, m_a);
        check("add_b", add_b, m_b);
        if (m_st == 2) check("rsp_s", rsp_s, sb[0]);
        case (m_st)
            0: if (eg0 || eg1) begin
                m_own = eg1;
                m_a   = eg1 ? req1_a : req0_a;
                m_b   = eg1 ? req1_b : req0_b;
                s     = {1'b0, m_a} + {1'b0, m_b};
                sb.push_back(s);
                grants.push_back(int'(eg1));
                m_st  = 1;
            end
            1: m_st = 2;
            default: begin
                take = m_own ? rsp1_ready : rsp0_ready;
                if (take) begin
                    void'(sb.pop_front());
                    m_last = m_own;
                    m_st   = 0;
                end
            end
        endcase
        @(posedge clk);
        #1;
        junk = 9'($urandom);
    endtask

    task automatic check_grant(input string tag, input int idx, input int exp);
        check(tag, (idx < grants.size()) ? grants[idx] : 99, exp);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_add_en", add_en, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_rsp_s", rsp_s, 0);
        check("rst_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single op from client 0.
        req0_valid = 1'b1; req0_a = 8'h0F; req0_b = 8'h01; rsp0_ready = 1'b1;
        observe();
        req0_valid = 1'b0;
        #1 check("single_add_en", add_en, 1);
        observe();
        check("single_rsp0_valid", rsp0_valid, 1);
        check("single_sum", rsp_s, 9'h010);
        check("single_busy", busy, 1);
        observe();
        check("single_idle_busy", busy, 0);

        // Carry from client 1.
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h01; rsp1_ready = 1'b1;
        observe();
        req1_valid = 1'b0;
        observe();
        check("carry_sum_100", rsp_s, 9'h100);
        observe();
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'hFF;
        observe();
        req1_valid = 1'b0;
        observe();
        check("carry_sum_1fe", rsp_s, 9'h1FE);
        observe();

        // Both requesting continuously after reset: strict alternation from client 0.
        rst_n = 1'b0;
        #2 model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        grants.delete();
        req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (12) begin
            req0_a = 8'($urandom); req0_b = 8'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom);
            observe();
        end
        check("arb_count", grants.size(), 4);
        check_grant("arb_g0", 0, 0);
        check_grant("arb_g1", 1, 1);
        check_grant("arb_g2", 2, 0);
        check_grant("arb_g3", 3, 1);

        // Client 1 alone, then both: client 0 must win.
        grants.delete();
        req0_valid = 1'b0;
        repeat (3) observe();
        req0_valid = 1'b1;
        repeat (3) observe();
        check_grant("solo_g0", 0, 1);
        check_grant("solo_g1", 1, 0);

        // Backpressure on client 0 while client 1 waits; rsp1_ready must be ignored.
        grants.delete();
        req1_valid = 1'b0; req0_valid = 1'b1; req0_a = 8'h3C; req0_b = 8'hC5;
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        observe();
        req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 8'h12; req1_b = 8'h34;
        observe();
        repeat (5) begin
            #1;
            check("bp_rsp0_valid", rsp0_valid, 1);
            check("bp_sum", rsp_s, 9'h101);
            check("bp_req1_ready", req1_ready, 0);
            check("bp_add_en", add_en, 0);
            observe();
        end
        rsp0_ready = 1'b1;
        observe();
        observe();
        req1_valid = 1'b0;
        observe();
        check("bp_rsp1_sum", rsp_s, 9'h046);
        observe();
        check_grant("bp_g0", 0, 0);
        check_grant("bp_g1", 1, 1);

        // Client 1 raises then drops valid while client 0 is in flight.
        grants.delete();
        req0_valid = 1'b1; req0_a = 8'h80; req0_b = 8'h80;
        observe();
        req0_valid = 1'b0; req1_valid = 1'b1;
        observe();
        req1_valid = 1'b0;
        observe();
        observe();
        check("drop_count", grants.size(), 1);

        // Asynchronous reset in the middle of EXEC.
        req0_valid = 1'b1; req0_a = 8'h55; req0_b = 8'h22;
        observe();
        req0_valid = 1'b0;
        #1 check("ar_pre_add_en", add_en, 1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_add_en", add_en, 0);
        check("ar_busy", busy, 0);
        check("ar_rsp0_valid", rsp0_valid, 0);
        check("ar_rsp1_valid", rsp1_valid, 0);
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) observe();
        grants.delete();
        req0_valid = 1'b1; req1_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02;
        observe();
        req0_valid = 1'b0; req1_valid = 1'b0;
        observe();
        check("ar_after_sum", rsp_s, 9'h003);
        observe();
        check_grant("ar_first_grant", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
